bioz_sweep_sequencer: RTL and testbench

//  Synthesizable successor to the behavioural stimulus generator. Drives a BioZ frequency sweep (Fsel

---
 rtl/bioz_seq_pkg.sv | 26 ++
 rtl/bioz_conv_framer.sv | 48 ++++
 rtl/bioz_sweep_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_bioz_sweep_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bioz_seq_pkg.sv
// Shared types and constants for the BioZ sweep sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package bioz_seq_pkg;

    // Sequencer states. SETTLE is only reachable when AFE_SETTLE_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Default frame constants.
    localparam int DEF_CONV_CYCLES   = 15;
    localparam int DEF_CONV_PER_STEP = 64;
    localparam int DEF_RST_CYCLES    = 8;
    localparam int DEF_SETTLE_CONV   = 4;

    // Width of a counter or select holding 0..n-1. Never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bioz_conv_framer.sv
// Conversion framer: cycles cnt_conv 0..CONV_CYCLES-1 and issues ADC_Start.
// Latency: ADC_Start is registered and appears 2 cycles after en_i first rises.
// Backpressure: none; en_i low clears the frame on the next edge.
module bioz_conv_framer
    import bioz_seq_pkg::*;
#(
    parameter int CONV_CYCLES = DEF_CONV_CYCLES
) (
    input  logic clk_ADC,
    input  logic Reset,
    input  logic en_i,
    input  logic pulse_en_i,
    output logic adc_start_o,
    output logic frame_end_o
);

    localparam int            CW      = clog2_min1(CONV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_conv_q, cnt_conv_d;
    logic          adc_start_q, adc_start_d;

    // Frame counter advance and start-pulse decode; idle frames park at zero.
    always_comb begin
        cnt_conv_d  = '0;
        adc_start_d = 1'b0;
        frame_end_o = en_i && (cnt_conv_q == CNT_LAST);
        if (en_i) begin
            cnt_conv_d  = (cnt_conv_q == CNT_LAST) ? '0 : cnt_conv_q + CNT_ONE;
            adc_start_d = pulse_en_i && (cnt_conv_q == CNT_ONE);
        end
    end

    // Frame state registers with synchronous reset.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            cnt_conv_q  <= '0;
            adc_start_q <= 1'b0;
        end else begin
            cnt_conv_q  <= cnt_conv_d;
            adc_start_q <= adc_start_d;
        end
    end

    assign adc_start_o = adc_start_q;

endmodule

// File: rtl/bioz_sweep_sequencer.sv
// BioZ sweep sequencer: steps Fsel down, scans Row/Col, frames ADC conversions.
// Latency: first ADC_Start 2 cycles after RUN entry; Abort/Reset take effect next cycle.
// Backpressure: none; Start only honoured in IDLE/DONE. Optional AFE_SETTLE_EN adds blanked frames.
module bioz_sweep_sequencer
    import bioz_seq_pkg::*;
#(
    parameter int FSEL_W        = 4,
    parameter int FSEL_START    = 10,
    parameter int FSEL_STOP     = 0,
    parameter int CONV_CYCLES   = DEF_CONV_CYCLES,
    parameter int CONV_PER_STEP = DEF_CONV_PER_STEP,
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int SETTLE_CONV   = DEF_SETTLE_CONV,
    localparam int ROW_W        = clog2_min1(N_ROWS),
    localparam int COL_W        = clog2_min1(N_COLS)
) (
    input  logic              clk_ADC,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Abort,
    input  logic              Continuous,
    output logic [FSEL_W-1:0] Fsel,
    output logic [ROW_W-1:0]  Row,
    output logic [COL_W-1:0]  Col,
    output logic              Resetn,
    output logic              Clk_En,
    output logic              ADC_En,
    output logic              ADC_Start,
    output logic              StepNum,
    output logic              Busy,
    output logic              Done
);

    localparam int                RST_W     = clog2_min1(RST_CYCLES);
    localparam int                STEP_W    = clog2_min1(CONV_PER_STEP);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(CONV_PER_STEP - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(N_COLS - 1);
    localparam logic [FSEL_W-1:0] FSEL_HI   = FSEL_W'(FSEL_START);
    localparam logic [FSEL_W-1:0] FSEL_LO   = FSEL_W'(FSEL_STOP);

    seq_state_t        state_q, state_d;
    logic [FSEL_W-1:0] fsel_q, fsel_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              stepnum_q, stepnum_d;
    logic [RST_W-1:0]  cnt_rst_q, cnt_rst_d;
    logic [STEP_W-1:0] cnt_step_q, cnt_step_d;

    logic frame_end;
    logic framer_en;
    logic rst_done;
    logic point_done;
    logic col_wrap, row_wrap, last_pt;
    logic enter_init;

`ifdef AFE_SETTLE_EN
    // After INIT and after every point advance the AFE gets blanked frames.
    localparam int               SET_W    = clog2_min1(SETTLE_CONV);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CONV - 1);
    localparam seq_state_t       ST_NEXT  = ST_SETTLE;
    logic [SET_W-1:0] cnt_settle_q, cnt_settle_d;
    logic             settle_done;
    assign settle_done = (state_q == ST_SETTLE) && frame_end && (cnt_settle_q == SET_LAST);
`else
    localparam seq_state_t       ST_NEXT  = ST_RUN;
`endif

    // Frame counter runs only while the ADC is enabled; Abort stops it the same edge.
    assign framer_en = ((state_q == ST_RUN) || (state_q == ST_SETTLE)) && !Abort;

    bioz_conv_framer #(
        .CONV_CYCLES (CONV_CYCLES)
    ) u_framer (
        .clk_ADC     (clk_ADC),
        .Reset       (Reset),
        .en_i        (framer_en),
        .pulse_en_i  (state_q == ST_RUN),
        .adc_start_o (ADC_Start),
        .frame_end_o (frame_end)
    );

    assign rst_done   = (state_q == ST_INIT) && (cnt_rst_q == RST_LAST);
    assign point_done = (state_q == ST_RUN) && frame_end && (cnt_step_q == STEP_LAST);
    assign col_wrap   = (col_q == COL_LAST);
    assign row_wrap   = (row_q == ROW_LAST);
    assign last_pt    = (fsel_q == FSEL_LO) && row_wrap && col_wrap;
    assign enter_init = (state_d == ST_INIT) && (state_q != ST_INIT);

    // State register.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; Abort overrides everything including Start.
    always_comb begin
        state_d = state_q;
        if (Abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (Start) state_d = ST_INIT;
                ST_INIT:          if (rst_done) state_d = ST_NEXT;
`ifdef AFE_SETTLE_EN
                ST_SETTLE:        if (settle_done) state_d = ST_RUN;
`endif
                ST_RUN: begin
                    if (point_done) begin
                        if (last_pt) state_d = Continuous ? ST_INIT : ST_DONE;
                        else         state_d = ST_NEXT;
                    end
                end
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        Resetn = 1'b1;
        Clk_En = 1'b1;
        ADC_En = 1'b0;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (state_q)
            ST_INIT: begin
                Resetn = 1'b0;
                Clk_En = 1'b0;
                Busy   = 1'b1;
            end
            ST_SETTLE, ST_RUN: begin
                ADC_En = 1'b1;
                Busy   = 1'b1;
            end
            ST_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    // Point/counter next-state: advance on the last frame of a point, reload on INIT entry.
    always_comb begin
        fsel_d     = fsel_q;
        row_d      = row_q;
        col_d      = col_q;
        stepnum_d  = stepnum_q;
        cnt_rst_d  = cnt_rst_q;
        cnt_step_d = cnt_step_q;
`ifdef AFE_SETTLE_EN
        cnt_settle_d = cnt_settle_q;
        if ((state_q == ST_SETTLE) && frame_end) begin
            cnt_settle_d = settle_done ? '0 : cnt_settle_q + SET_W'(1);
        end
`endif
        if (state_q == ST_INIT) begin
            cnt_rst_d = rst_done ? '0 : cnt_rst_q + RST_W'(1);
        end
        if ((state_q == ST_RUN) && frame_end) begin
            cnt_step_d = point_done ? '0 : cnt_step_q + STEP_W'(1);
        end
        if (point_done) begin
            stepnum_d = ~stepnum_q;
            col_d     = col_wrap ? '0 : col_q + COL_W'(1);
            if (col_wrap) begin
                row_d = row_wrap ? '0 : row_q + ROW_W'(1);
                // Fsel is held at the stop value on the final point.
                if (row_wrap && (fsel_q != FSEL_LO)) fsel_d = fsel_q - FSEL_W'(1);
            end
        end
        if (enter_init) begin
            fsel_d     = FSEL_HI;
            row_d      = '0;
            col_d      = '0;
            cnt_rst_d  = '0;
            cnt_step_d = '0;
`ifdef AFE_SETTLE_EN
            cnt_settle_d = '0;
`endif
        end
        // Abort leaves the scan position visible but drops all progress.
        if (Abort) begin
            stepnum_d  = 1'b0;
            cnt_rst_d  = '0;
            cnt_step_d = '0;
`ifdef AFE_SETTLE_EN
            cnt_settle_d = '0;
`endif
        end
    end

    // Point and counter registers.
    always_ff @(posedge clk_ADC) begin
        if (Reset) begin
            fsel_q     <= FSEL_HI;
            row_q      <= '0;
            col_q      <= '0;
            stepnum_q  <= 1'b0;
            cnt_rst_q  <= '0;
            cnt_step_q <= '0;
`ifdef AFE_SETTLE_EN
            cnt_settle_q <= '0;
`endif
        end else begin
            fsel_q     <= fsel_d;
            row_q      <= row_d;
            col_q      <= col_d;
            stepnum_q  <= stepnum_d;
            cnt_rst_q  <= cnt_rst_d;
            cnt_step_q <= cnt_step_d;
`ifdef AFE_SETTLE_EN
            cnt_settle_q <= cnt_settle_d;
`endif
        end
    end

    assign Fsel    = fsel_q;
    assign Row     = row_q;
    assign Col     = col_q;
    assign StepNum = stepnum_q;

endmodule

// File: tb/tb_bioz_sweep_sequencer.sv
// Bench for bioz_sweep_sequencer: default-parameter instance plus a small 12-point instance.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_bioz_sweep_sequencer;

`ifdef AFE_SETTLE_EN
    localparam int SETTLE_CYC = 60;
`else
    localparam int SETTLE_CYC = 0;
`endif

    logic clk_ADC = 1'b0;
    always #5 clk_ADC = ~clk_ADC;

    // Default-parameter instance.
    logic       d_rst, d_start, d_abort, d_cont;
    logic [3:0] d_fsel;
    logic [1:0] d_row, d_col;
    logic       d_resetn, d_clken, d_adcen, d_adcstart, d_step, d_busy, d_done;

    // Small instance: Fsel 2..0, 2x2 electrodes, 2 conversions per point.
    logic       s_rst, s_start, s_abort, s_cont;
    logic [3:0] s_fsel;
    logic [0:0] s_row, s_col;
    logic       s_resetn, s_clken, s_adcen, s_adcstart, s_step, s_busy, s_done;

    bioz_sweep_sequencer u_def (
        .clk_ADC (clk_ADC), .Reset (d_rst), .Start (d_start), .Abort (d_abort),
        .Continuous (d_cont), .Fsel (d_fsel), .Row (d_row), .Col (d_col),
        .Resetn (d_resetn), .Clk_En (d_clken), .ADC_En (d_adcen), .ADC_Start (d_adcstart),
        .StepNum (d_step), .Busy (d_busy), .Done (d_done)
    );

    bioz_sweep_sequencer #(
        .FSEL_START (2), .FSEL_STOP (0), .N_ROWS (2), .N_COLS (2), .CONV_PER_STEP (2)
    ) u_small (
        .clk_ADC (clk_ADC), .Reset (s_rst), .Start (s_start), .Abort (s_abort),
        .Continuous (s_cont), .Fsel (s_fsel), .Row (s_row), .Col (s_col),
        .Resetn (s_resetn), .Clk_En (s_clken), .ADC_En (s_adcen), .ADC_Start (s_adcstart),
        .StepNum (s_step), .Busy (s_busy), .Done (s_done)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       abort;
        int         n;
        logic       resetn;
        logic       adc_en;
        logic       adc_start;
        logic       busy;
        logic       done;
        logic [3:0] fsel;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    int checks = 0;
    int errors = 0;

    int   tog, pip, guard, pulses, p, t, t_run, t_p0, t_p1, t_p2, t_last;
    logic prev_step, seen_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_ADC);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        d_rst = 1'b1; d_start = 1'b0; d_abort = 1'b0; d_cont = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_cont = 1'b0;

        // rst start abort n | resetn adc_en adc_start busy done fsel
        vt[0]  = '{1'b1, 1'b0, 1'b0, 5,              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10}; // reset state
        vt[1]  = '{1'b0, 1'b1, 1'b0, 1,              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10}; // INIT cycle 1
        vt[2]  = '{1'b0, 1'b0, 1'b0, 6,              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10}; // INIT cycle 7
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1,              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10}; // INIT cycle 8
        vt[4]  = '{1'b0, 1'b0, 1'b0, 1,              1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10}; // ADC enabled
        vt[5]  = '{1'b0, 1'b0, 1'b0, 1 + SETTLE_CYC, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10}; // RUN +1
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1,              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd10}; // first pulse
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1,              1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10}; // one cycle wide
        vt[8]  = '{1'b0, 1'b0, 1'b0, 13,             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10}; // period -1
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1,              1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd10}; // period 15
        vt[10] = '{1'b0, 1'b0, 1'b0, 14,             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd10}; // pulse due next
        vt[11] = '{1'b0, 1'b1, 1'b1, 1,              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10}; // Abort+Start
        vt[12] = '{1'b0, 1'b0, 1'b0, 2,              1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10}; // stays IDLE
        vt[13] = '{1'b0, 1'b1, 1'b0, 1,              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd10}; // fresh Start

        for (int i = 0; i < NV; i++) begin
            d_rst   = vt[i].rst;
            d_start = vt[i].start;
            d_abort = vt[i].abort;
            repeat (vt[i].n) tick();
            chk($sformatf("v%0d_resetn", i),    d_resetn,   vt[i].resetn);
            chk($sformatf("v%0d_clk_en", i),    d_clken,    vt[i].resetn);
            chk($sformatf("v%0d_adc_en", i),    d_adcen,    vt[i].adc_en);
            chk($sformatf("v%0d_adc_start", i), d_adcstart, vt[i].adc_start);
            chk($sformatf("v%0d_busy", i),      d_busy,     vt[i].busy);
            chk($sformatf("v%0d_done", i),      d_done,     vt[i].done);
            chk($sformatf("v%0d_fsel", i),      d_fsel,     vt[i].fsel);
            chk($sformatf("v%0d_row", i),       d_row,      0);
            chk($sformatf("v%0d_col", i),       d_col,      0);
            chk($sformatf("v%0d_stepnum", i),   d_step,     0);
        end
        d_rst = 1'b0; d_start = 1'b0; d_abort = 1'b0;

        // Reset during the 3rd conversion of point 5 (Row=1, Col=0 on a 4x4 scan).
        tog = 0; pip = 0; guard = 0; prev_step = d_step;
        while (!(tog == 4 && pip == 3) && guard < 20000) begin
            tick(); guard++;
            if (d_step !== prev_step) begin tog++; pip = 0; prev_step = d_step; end
            if (d_adcstart) pip++;
        end
        chk("mid_reached", 32'(guard < 20000), 1);
        chk("mid_row", d_row, 1);
        chk("mid_col", d_col, 0);
        chk("mid_fsel", d_fsel, 10);
        d_rst = 1'b1;
        tick();
        d_rst = 1'b0;
        chk("rst_fsel", d_fsel, 10);
        chk("rst_row", d_row, 0);
        chk("rst_col", d_col, 0);
        chk("rst_resetn", d_resetn, 1);
        chk("rst_clk_en", d_clken, 1);
        chk("rst_adc_en", d_adcen, 0);
        chk("rst_adc_start", d_adcstart, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_done", d_done, 0);
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        chk("restart_resetn", d_resetn, 0);
        chk("restart_busy", d_busy, 1);
        d_abort = 1'b1;

        // Full 12-point sweep on the small instance.
        s_rst = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        pulses = 0; tog = 0; t = 0; t_run = -1; t_p0 = -1; t_p1 = -1; t_p2 = -1; t_last = -1;
        prev_step = s_step;
        while (!s_done && t < 5000) begin
            tick(); t++;
            if (t_run < 0 && s_adcen) t_run = t;
            if (s_step !== prev_step) begin tog++; prev_step = s_step; end
            if (s_adcstart) begin
                p = pulses / 2;
                chk($sformatf("pt%0d_fsel", p), s_fsel, 2 - p / 4);
                chk($sformatf("pt%0d_row", p), s_row, (p / 2) % 2);
                chk($sformatf("pt%0d_col", p), s_col, p % 2);
                if (pulses == 0) t_p0 = t;
                if (pulses == 1) t_p1 = t;
                if (pulses == 2) t_p2 = t;
                t_last = t;
                pulses++;
            end
        end
        chk("sweep_done", s_done, 1);
        chk("sweep_busy", s_busy, 0);
        chk("sweep_pulses", pulses, 24);
        chk("sweep_toggles", tog, 12);
        chk("sweep_fsel_stop", s_fsel, 0);
        chk("first_pulse_ofs", t_p0 - t_run, 2 + SETTLE_CYC);
        chk("advance_gap", t_p2 - t_p1, 15 + SETTLE_CYC);
        chk("done_after_frame", t - t_last, 13);

        // Continuous: last point re-enters INIT with a reloaded scan position.
        s_cont = 1'b1; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        tog = 0; t = 0; seen_done = 1'b0; prev_step = s_step;
        while (tog < 12 && t < 5000) begin
            tick(); t++;
            if (s_done) seen_done = 1'b1;
            if (s_step !== prev_step) begin tog++; prev_step = s_step; end
        end
        chk("cont_toggles", tog, 12);
        chk("cont_resetn", s_resetn, 0);
        chk("cont_fsel", s_fsel, 2);
        chk("cont_row", s_row, 0);
        chk("cont_col", s_col, 0);
        chk("cont_busy", s_busy, 1);
        repeat (40) begin
            tick();
            if (s_done) seen_done = 1'b1;
        end
        chk("cont_no_done", seen_done, 0);

        // Abort together with Start on the cycle before a pulse would fire.
        guard = 0;
        while (!s_adcstart && guard < 500) begin tick(); guard++; end
        chk("abort_pulse_seen", 32'(guard < 500), 1);
        repeat (14) tick();
        chk("abort_pre_adc_en", s_adcen, 1);
        s_abort = 1'b1; s_start = 1'b1;
        tick();
        s_abort = 1'b0; s_start = 1'b0;
        chk("abort_adc_en", s_adcen, 0);
        chk("abort_adc_start", s_adcstart, 0);
        chk("abort_busy", s_busy, 0);
        chk("abort_done", s_done, 0);
        chk("abort_resetn", s_resetn, 1);
        repeat (3) tick();
        chk("abort_stays_idle", s_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
